fdt_search: RTL and testbench
=============================

# fdt_search

Front end of the allocation pipeline. Holds the FDT summary table: one row per AT line, one bit per size class, with 1 meaning that AT line is full for that class. It accepts allocation requests from the request queue and finds the first non-full AT line for the requested size. It then issues the search request into the AND-tree, or reports failure, and absorbs the FDT update stream the AND-tree emits after every AT-tree write.

## Interface
Parameters:
- FDT_DEPTH, default 1<<`FDT_INDEX_WIDTH: number of table rows, one per AT line.
- WAIT_MAX, default 31: maximum cycles spent waiting for the releasing FDT update before the watchdog fires.

Ports:
- clk  in  1  single clock; all logic is synchronous, registered on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  allocation request present.
- req_ready  out  1  block accepts a request this cycle.
- req_id  in  `REQ_ID_WIDTH  request tag.
- req_size  in  `REQ_SIZE_TYPE_WIDTH  aligned size code (`REQ_512/`REQ_1K/`REQ_2K/`REQ_4K).
- req_origin_size  in  `REQ_SIZE_TYPE_WIDTH  unaligned size, passed through unchanged.
- alloc_valid_fdt_out  out  1  one-cycle pulse; search request to the AND-tree.
- alloc_id_fdt_out  out  `REQ_ID_WIDTH  tag of the request being issued.
- alloc_pos_fdt_out  out  `AT_TREE_INDEX_WIDTH  AT line to read (the FDT row index).
- alloc_size_fdt_out  out  `REQ_SIZE_TYPE_WIDTH  aligned size of the issued request.
- alloc_origin_size_fdt_out  out  `REQ_SIZE_TYPE_WIDTH  original size of the issued request.
- fail_valid  out  1  one-cycle pulse; no free line of that class, or illegal size code.
- fail_id  out  `REQ_ID_WIDTH  tag of the failed request.
- fdt_update_valid  in  1  table write strobe from the AND-tree.
- fdt_update_idx  in  `FDT_INDEX_WIDTH  row to write.
- fdt_update_bit_sequence  in  `FDT_BIT_WIDTH  new row value; bit0=512, bit1=1K, bit2=2K, bit3=4K.
- wait_timeout  out  1  one-cycle pulse when the watchdog fires.

## Operation
- Table: FDT_DEPTH × `FDT_BIT_WIDTH flops. Reset clears every row to 0 (all lines free).
- Every fdt_update_valid overwrites row fdt_update_idx, in every state.
- Request flow: FSM IDLE → SEARCH → ISSUE → WAIT → IDLE.
  - IDLE: req_ready=1. On req_valid, latch id, size and origin_size, then go to SEARCH.
  - SEARCH: map the size code to a class bit. Build a column vector from that bit of every row, with a same-cycle update forwarded: if fdt_update_valid, row fdt_update_idx uses fdt_update_bit_sequence. Find the lowest index whose bit is 0 and register the index plus a found flag. Go to ISSUE.
  - ISSUE:
    - If found: pulse alloc_* with pos = the found index, latch pending_pos, clear the watchdog, go to WAIT.
    - Else (not found, or illegal size code): pulse fail_valid/fail_id and go to IDLE.
  - WAIT: the watchdog counts up.
    - Leave to IDLE on the first fdt_update_valid with idx == pending_pos. This prevents two requests claiming the same free slot before the OR-tree marks it used.
    - Else, when the counter reaches WAIT_MAX: pulse wait_timeout and go to IDLE.
- Updates to other rows during WAIT are applied to the table and do not release the FSM.
- Exactly one of alloc_valid_fdt_out and fail_valid pulses per accepted request.

## Timing
- Reset values: req_ready=0 during reset, then 1 in IDLE. All alloc_*, fail_*, and wait_timeout are 0. FSM=IDLE, watchdog=0, pending_pos=0.
- Reset asserted mid-operation aborts the in-flight request silently, with no fail pulse, and clears the table.
- Latency: request accepted at edge E. alloc_valid_fdt_out or fail_valid is high in the cycle following edge E+2 and low otherwise.
- Throughput: one request per round trip. req_ready stays low from acceptance until the FSM returns to IDLE.
- The alloc_* bus and fail_id are 0 whenever their valid is 0.
- A table write at edge E is visible to a SEARCH in the cycle before E (forwarding) and in all later cycles.
- Release on a matching update moves to IDLE on that same edge; req_ready is high in the next cycle.
- Watchdog: WAIT for WAIT_MAX+1 cycles without a matching update produces a wait_timeout pulse on exit.

## Structure
- Size codes, FDT/AT widths, and the size-code→class-bit mapping live in mmu_param.vh; no local redefinition.
- One sub-module: fdt_first_free, a combinational parameterised lowest-zero priority encoder, FDT_DEPTH wide, with index and found outputs. It mirrors first_zero and is reusable by the free path.
- The FSM, table, forwarding mux, and watchdog live in fdt_search.

## Test plan
- Reset, then 512 request id=3 → alloc pulse with pos=0, size=`REQ_512, 2 cycles after accept. Then update idx=0 seq=4'b0001 → req_ready=1 next cycle.
- Rows 0–2 bit1 set via updates, then 1K request id=7 → alloc pos=3. A subsequent 512 request → pos=0.
- All rows bit3=1, 4K request id=9 → fail_valid with fail_id=9, no alloc pulse, back in IDLE.
- Update idx=0 seq=4'b0001 in the same cycle as SEARCH for 512 → pos=1 (forwarding).
- In WAIT, pending_pos=5: update idx=2 does not release; update idx=5 releases. With no update at all → wait_timeout after 32 WAIT cycles.
- Reset asserted in WAIT → no pulses, table cleared, the next 4K request gets pos=0.

Source files
------------

// File: rtl/fdt_search_pkg.sv
// Shared MMU widths, size codes and the size-code to FDT class-bit mapping.
package fdt_search_pkg;

  localparam int FDT_INDEX_WIDTH     = 4;
  localparam int FDT_BIT_WIDTH       = 4;
  localparam int AT_TREE_INDEX_WIDTH = FDT_INDEX_WIDTH;
  localparam int REQ_ID_WIDTH        = 8;
  localparam int REQ_SIZE_TYPE_WIDTH = 3;

  typedef logic [REQ_SIZE_TYPE_WIDTH-1:0] size_t;

  localparam size_t REQ_512 = 3'd0;
  localparam size_t REQ_1K  = 3'd1;
  localparam size_t REQ_2K  = 3'd2;
  localparam size_t REQ_4K  = 3'd3;

  // Latched allocation request.
  typedef struct packed {
    logic [REQ_ID_WIDTH-1:0] id;
    size_t                   size;
    size_t                   origin_size;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_ISSUE, S_WAIT} state_t;

  // One-hot class bit for a size code; all-zero marks an illegal code.
  function automatic logic [FDT_BIT_WIDTH-1:0] class_mask(input size_t size);
    logic [FDT_BIT_WIDTH-1:0] m;
    m = '0;
    case (size)
      REQ_512: m[0] = 1'b1;
      REQ_1K:  m[1] = 1'b1;
      REQ_2K:  m[2] = 1'b1;
      REQ_4K:  m[3] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/fdt_search_if.sv
// Request, issue/fail and FDT-update bus between the request queue / AND-tree
// (master) and fdt_search (slave).
interface fdt_search_if;
  import fdt_search_pkg::*;

  logic                           req_valid;
  logic                           req_ready;
  logic [REQ_ID_WIDTH-1:0]        req_id;
  logic [REQ_SIZE_TYPE_WIDTH-1:0] req_size;
  logic [REQ_SIZE_TYPE_WIDTH-1:0] req_origin_size;

  logic                           alloc_valid_fdt_out;
  logic [REQ_ID_WIDTH-1:0]        alloc_id_fdt_out;
  logic [AT_TREE_INDEX_WIDTH-1:0] alloc_pos_fdt_out;
  logic [REQ_SIZE_TYPE_WIDTH-1:0] alloc_size_fdt_out;
  logic [REQ_SIZE_TYPE_WIDTH-1:0] alloc_origin_size_fdt_out;

  logic                           fail_valid;
  logic [REQ_ID_WIDTH-1:0]        fail_id;

  logic                           fdt_update_valid;
  logic [FDT_INDEX_WIDTH-1:0]     fdt_update_idx;
  logic [FDT_BIT_WIDTH-1:0]       fdt_update_bit_sequence;

  modport master (
    output req_valid, req_id, req_size, req_origin_size,
    output fdt_update_valid, fdt_update_idx, fdt_update_bit_sequence,
    input  req_ready,
    input  alloc_valid_fdt_out, alloc_id_fdt_out, alloc_pos_fdt_out,
    input  alloc_size_fdt_out, alloc_origin_size_fdt_out,
    input  fail_valid, fail_id
  );

  modport slave (
    input  req_valid, req_id, req_size, req_origin_size,
    input  fdt_update_valid, fdt_update_idx, fdt_update_bit_sequence,
    output req_ready,
    output alloc_valid_fdt_out, alloc_id_fdt_out, alloc_pos_fdt_out,
    output alloc_size_fdt_out, alloc_origin_size_fdt_out,
    output fail_valid, fail_id
  );

endinterface

// File: rtl/fdt_search_first_free.sv
// Lowest-zero priority encoder over the FDT column; shared with the free path.
module fdt_first_free #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan high to low so the lowest zero wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fdt_search.sv
// FDT summary table plus request FSM: finds the first non-full AT line for a
// size class, issues it to the AND-tree and holds off until that line's update.
module fdt_search
  import fdt_search_pkg::*;
#(
  parameter int FDT_DEPTH = 1 << FDT_INDEX_WIDTH,
  parameter int WAIT_MAX  = 31
) (
  input  logic         clk,
  input  logic         rst,
  fdt_search_if.slave  bus,
  output logic         wait_timeout
);

  localparam int WD_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

  state_t state, state_n;
  req_t   req_q;

  logic [FDT_BIT_WIDTH-1:0]   fdt_tbl [FDT_DEPTH];
  logic [FDT_DEPTH-1:0]       row_wr;
  logic [FDT_DEPTH-1:0]       col;
  logic [FDT_BIT_WIDTH-1:0]   cls_mask;

  logic [FDT_INDEX_WIDTH-1:0] ff_idx, hit_idx_q, pend_pos;
  logic                       ff_found, hit_q;
  logic [WD_W-1:0]            wdog;
  logic                       release_hit;

  logic                           alloc_vld_n, fail_vld_n, tmo_n;
  logic                           alloc_vld_q, fail_vld_q, tmo_q;
  logic [REQ_ID_WIDTH-1:0]        alloc_id_q, fail_id_q;
  logic [AT_TREE_INDEX_WIDTH-1:0] alloc_pos_q;
  logic [REQ_SIZE_TYPE_WIDTH-1:0] alloc_size_q, alloc_osz_q;

  assign cls_mask = class_mask(req_q.size);

  // Per-row write decode and column build; a same-cycle update is forwarded so
  // the search never picks a line the AND-tree is marking full right now.
  for (genvar r = 0; r < FDT_DEPTH; r++) begin : g_row
    localparam logic [FDT_INDEX_WIDTH-1:0] ROW = FDT_INDEX_WIDTH'(r);
    logic [FDT_BIT_WIDTH-1:0] row_view;
    assign row_wr[r] = bus.fdt_update_valid && (bus.fdt_update_idx == ROW);
    assign row_view  = row_wr[r] ? bus.fdt_update_bit_sequence : fdt_tbl[r];
    assign col[r]    = |(row_view & cls_mask);
  end

  fdt_first_free #(
    .WIDTH (FDT_DEPTH),
    .IDX_W (FDT_INDEX_WIDTH)
  ) u_first_free (
    .vec   (col),
    .idx   (ff_idx),
    .found (ff_found)
  );

  assign release_hit = bus.fdt_update_valid && (bus.fdt_update_idx == pend_pos);

  // Table rows: cleared on reset, overwritten by every update regardless of state.
  always_ff @(posedge clk) begin
    for (int r = 0; r < FDT_DEPTH; r++) begin
      if (rst)            fdt_tbl[r] <= '0;
      else if (row_wr[r]) fdt_tbl[r] <= bus.fdt_update_bit_sequence;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next state and next-cycle pulse requests.
  always_comb begin
    state_n     = state;
    alloc_vld_n = 1'b0;
    fail_vld_n  = 1'b0;
    tmo_n       = 1'b0;
    case (state)
      S_IDLE:   if (bus.req_valid) state_n = S_SEARCH;
      S_SEARCH: state_n = S_ISSUE;
      S_ISSUE: begin
        if (hit_q) begin
          alloc_vld_n = 1'b1;
          state_n     = S_WAIT;
        end else begin
          fail_vld_n  = 1'b1;
          state_n     = S_IDLE;
        end
      end
      S_WAIT: begin
        // Hold until the claimed line's update lands, so a second request
        // cannot grab the same free slot before it is marked used.
        if (release_hit) begin
          state_n = S_IDLE;
        end else if (wdog == WD_W'(WAIT_MAX)) begin
          tmo_n   = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Request latch, search result, pending line, watchdog and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q        <= '0;
      hit_q        <= 1'b0;
      hit_idx_q    <= '0;
      pend_pos     <= '0;
      wdog         <= '0;
      alloc_vld_q  <= 1'b0;
      alloc_id_q   <= '0;
      alloc_pos_q  <= '0;
      alloc_size_q <= '0;
      alloc_osz_q  <= '0;
      fail_vld_q   <= 1'b0;
      fail_id_q    <= '0;
      tmo_q        <= 1'b0;
    end else begin
      if (state == S_IDLE && bus.req_valid)
        req_q <= '{id: bus.req_id, size: bus.req_size, origin_size: bus.req_origin_size};
      if (state == S_SEARCH) begin
        // Illegal size codes have an empty class mask and always fail.
        hit_q     <= ff_found && (|cls_mask);
        hit_idx_q <= ff_idx;
      end
      if (alloc_vld_n) pend_pos <= hit_idx_q;
      if (state == S_WAIT && state_n == S_WAIT) wdog <= wdog + 1'b1;
      else                                      wdog <= '0;
      alloc_vld_q  <= alloc_vld_n;
      alloc_id_q   <= alloc_vld_n ? req_q.id          : '0;
      alloc_pos_q  <= alloc_vld_n ? hit_idx_q         : '0;
      alloc_size_q <= alloc_vld_n ? req_q.size        : '0;
      alloc_osz_q  <= alloc_vld_n ? req_q.origin_size : '0;
      fail_vld_q   <= fail_vld_n;
      fail_id_q    <= fail_vld_n ? req_q.id : '0;
      tmo_q        <= tmo_n;
    end
  end

  assign bus.req_ready                 = (state == S_IDLE) && !rst;
  assign bus.alloc_valid_fdt_out       = alloc_vld_q;
  assign bus.alloc_id_fdt_out          = alloc_id_q;
  assign bus.alloc_pos_fdt_out         = alloc_pos_q;
  assign bus.alloc_size_fdt_out        = alloc_size_q;
  assign bus.alloc_origin_size_fdt_out = alloc_osz_q;
  assign bus.fail_valid                = fail_vld_q;
  assign bus.fail_id                   = fail_id_q;
  assign wait_timeout                  = tmo_q;

endmodule

// File: tb/tb_fdt_search.sv
// Directed bench for fdt_search: vector table plus hand-written WAIT/reset cases.
module tb_fdt_search;
  import fdt_search_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wait_timeout;

  always #5 clk = ~clk;

  fdt_search_if bus();

  fdt_search #(.FDT_DEPTH(16), .WAIT_MAX(31)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .wait_timeout (wait_timeout)
  );

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    logic       pre_en;
    logic [3:0] pre_idx;
    logic [3:0] pre_seq;
    logic [7:0] id;
    logic [2:0] sz;
    logic       exp_alloc;
    logic [3:0] exp_pos;
    logic [3:0] rel_seq;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [3:0] idx, input logic [3:0] seq);
    bus.fdt_update_valid        = 1'b1;
    bus.fdt_update_idx          = idx;
    bus.fdt_update_bit_sequence = seq;
    step();
    bus.fdt_update_valid        = 1'b0;
  endtask

  // Present one request, optionally forward an update during SEARCH, and
  // record the first alloc/fail pulse within a bounded window.
  task automatic issue(input logic [7:0] id, input logic [2:0] sz,
                       input logic fwd, input logic [3:0] fidx, input logic [3:0] fseq,
                       output int lat, output logic got_a, output logic got_f,
                       output logic [3:0] pos, output logic [7:0] aid,
                       output logic [2:0] asz, output logic [2:0] aosz,
                       output logic [7:0] fid);
    chk("ready_before_req", bus.req_ready, 1);
    bus.req_valid       = 1'b1;
    bus.req_id          = id;
    bus.req_size        = sz;
    bus.req_origin_size = ~sz;
    step();
    bus.req_valid = 1'b0;
    if (fwd) begin
      bus.fdt_update_valid        = 1'b1;
      bus.fdt_update_idx          = fidx;
      bus.fdt_update_bit_sequence = fseq;
    end
    lat = -1; got_a = 1'b0; got_f = 1'b0;
    pos = '0; aid = '0; asz = '0; aosz = '0; fid = '0;
    for (int k = 1; k <= 6; k++) begin
      step();
      bus.fdt_update_valid = 1'b0;
      if (k == 1) chk("ready_low_busy", bus.req_ready, 0);
      if (bus.alloc_valid_fdt_out || bus.fail_valid) begin
        lat   = k;
        got_a = bus.alloc_valid_fdt_out;
        got_f = bus.fail_valid;
        pos   = bus.alloc_pos_fdt_out;
        aid   = bus.alloc_id_fdt_out;
        asz   = bus.alloc_size_fdt_out;
        aosz  = bus.alloc_origin_size_fdt_out;
        fid   = bus.fail_id;
        break;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int         lat;
    int         cnt;
    logic       ga, gf;
    logic [3:0] pos;
    logic [7:0] aid, fid;
    logic [2:0] asz, aosz, osz;

    bus.req_valid = 1'b0; bus.req_id = '0; bus.req_size = '0; bus.req_origin_size = '0;
    bus.fdt_update_valid = 1'b0; bus.fdt_update_idx = '0; bus.fdt_update_bit_sequence = '0;

    //        pre  idx   seq      id     size     alloc pos  release
    vt[0] = '{1'b0, 4'd0, 4'b0000, 8'd3,  REQ_512, 1'b1, 4'd0, 4'b0001};
    vt[1] = '{1'b1, 4'd1, 4'b0010, 8'd4,  REQ_1K,  1'b1, 4'd0, 4'b0010};
    vt[2] = '{1'b1, 4'd2, 4'b0010, 8'd7,  REQ_1K,  1'b1, 4'd3, 4'b0010};
    vt[3] = '{1'b0, 4'd0, 4'b0000, 8'd8,  REQ_512, 1'b1, 4'd0, 4'b0011};
    vt[4] = '{1'b0, 4'd0, 4'b0000, 8'd10, REQ_2K,  1'b1, 4'd0, 4'b0111};
    vt[5] = '{1'b0, 4'd0, 4'b0000, 8'd11, 3'd5,    1'b0, 4'd0, 4'b0000};
    vt[6] = '{1'b0, 4'd0, 4'b0000, 8'd12, REQ_4K,  1'b1, 4'd0, 4'b1111};
    vt[7] = '{1'b1, 4'd1, 4'b1010, 8'd13, REQ_4K,  1'b1, 4'd2, 4'b1010};
    vt[8] = '{1'b0, 4'd0, 4'b0000, 8'd14, 3'd7,    1'b0, 4'd0, 4'b0000};

    // Reset state.
    repeat (3) step();
    chk("rst_ready",   bus.req_ready, 0);
    chk("rst_alloc",   bus.alloc_valid_fdt_out, 0);
    chk("rst_pos",     bus.alloc_pos_fdt_out, 0);
    chk("rst_fail",    bus.fail_valid, 0);
    chk("rst_timeout", wait_timeout, 0);
    rst = 1'b0;
    step();
    chk("idle_ready", bus.req_ready, 1);

    // Table-driven requests.
    for (int i = 0; i < 9; i++) begin
      if (vt[i].pre_en) upd(vt[i].pre_idx, vt[i].pre_seq);
      issue(vt[i].id, vt[i].sz, 1'b0, 4'd0, 4'd0, lat, ga, gf, pos, aid, asz, aosz, fid);
      osz = ~vt[i].sz;
      chk($sformatf("v%0d_latency", i), lat, 2);
      chk($sformatf("v%0d_alloc", i), ga, vt[i].exp_alloc);
      chk($sformatf("v%0d_fail", i), gf, !vt[i].exp_alloc);
      if (vt[i].exp_alloc) begin
        chk($sformatf("v%0d_pos", i), pos, vt[i].exp_pos);
        chk($sformatf("v%0d_id", i), aid, vt[i].id);
        chk($sformatf("v%0d_size", i), asz, vt[i].sz);
        chk($sformatf("v%0d_osize", i), aosz, osz);
        chk($sformatf("v%0d_ready_wait", i), bus.req_ready, 0);
        upd(vt[i].exp_pos, vt[i].rel_seq);
        chk($sformatf("v%0d_ready_release", i), bus.req_ready, 1);
        chk($sformatf("v%0d_alloc_low", i), bus.alloc_valid_fdt_out, 0);
        chk($sformatf("v%0d_pos_zero", i), bus.alloc_pos_fdt_out, 0);
      end else begin
        chk($sformatf("v%0d_fail_id", i), fid, vt[i].id);
        chk($sformatf("v%0d_ready_fail", i), bus.req_ready, 1);
        step();
        chk($sformatf("v%0d_fail_low", i), bus.fail_valid, 0);
        chk($sformatf("v%0d_fail_id_zero", i), bus.fail_id, 0);
      end
    end

    // Every line full for 4K: request fails.
    for (int r = 0; r < 16; r++) upd(4'(r), 4'b1000);
    issue(8'd9, REQ_4K, 1'b0, 4'd0, 4'd0, lat, ga, gf, pos, aid, asz, aosz, fid);
    chk("full4k_latency", lat, 2);
    chk("full4k_fail", gf, 1);
    chk("full4k_no_alloc", ga, 0);
    chk("full4k_fail_id", fid, 9);
    chk("full4k_ready", bus.req_ready, 1);

    // Update to row 0 during SEARCH is forwarded: 512 lands on row 1.
    issue(8'd20, REQ_512, 1'b1, 4'd0, 4'b0001, lat, ga, gf, pos, aid, asz, aosz, fid);
    chk("fwd_alloc", ga, 1);
    chk("fwd_pos", pos, 1);
    upd(4'd1, 4'b1001);
    chk("fwd_release", bus.req_ready, 1);

    // WAIT on row 5: an update to row 2 does not release, row 5 does.
    upd(4'd2, 4'b1001); upd(4'd3, 4'b1001); upd(4'd4, 4'b1001);
    issue(8'd21, REQ_512, 1'b0, 4'd0, 4'd0, lat, ga, gf, pos, aid, asz, aosz, fid);
    chk("wait_pos", pos, 5);
    upd(4'd2, 4'b1001);
    chk("wait_other_row", bus.req_ready, 0);
    step();
    chk("wait_still", bus.req_ready, 0);
    upd(4'd5, 4'b1001);
    chk("wait_release", bus.req_ready, 1);
    chk("wait_no_timeout", wait_timeout, 0);

    // No matching update: watchdog fires after 32 WAIT cycles.
    issue(8'd22, REQ_512, 1'b0, 4'd0, 4'd0, lat, ga, gf, pos, aid, asz, aosz, fid);
    chk("tmo_pos", pos, 6);
    cnt = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (c == 31) chk("tmo_ready_c31", bus.req_ready, 0);
      if (wait_timeout) begin
        cnt = c;
        break;
      end
    end
    chk("tmo_cycles", cnt, 32);
    chk("tmo_ready", bus.req_ready, 1);
    step();
    chk("tmo_pulse_end", wait_timeout, 0);

    // Reset while in WAIT: silent abort, table cleared.
    issue(8'd23, REQ_512, 1'b0, 4'd0, 4'd0, lat, ga, gf, pos, aid, asz, aosz, fid);
    chk("rwait_pos", pos, 6);
    step(); step();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rwait_ready", bus.req_ready, 0);
      chk("rwait_alloc", bus.alloc_valid_fdt_out, 0);
      chk("rwait_fail", bus.fail_valid, 0);
      chk("rwait_timeout", wait_timeout, 0);
    end
    rst = 1'b0;
    step();
    chk("rwait_ready_after", bus.req_ready, 1);
    issue(8'd24, REQ_4K, 1'b0, 4'd0, 4'd0, lat, ga, gf, pos, aid, asz, aosz, fid);
    chk("rwait_4k_alloc", ga, 1);
    chk("rwait_4k_pos", pos, 0);
    upd(4'd0, 4'b1000);
    issue(8'd25, REQ_512, 1'b0, 4'd0, 4'd0, lat, ga, gf, pos, aid, asz, aosz, fid);
    chk("rwait_512_alloc", ga, 1);
    chk("rwait_512_pos", pos, 0);
    upd(4'd0, 4'b1001);
    chk("rwait_512_release", bus.req_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
